// File: rtl/booth_div_pkg.sv
// ============================================================================
// Module   : booth_div_pkg
// Purpose  : Shared types, widths and helpers for the signed 16/8 divider.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package booth_div_pkg;

    localparam int DVD_W = 16;
    localparam int DVS_W = 8;
    localparam int Q_W   = 8;
    localparam int ITER  = 16;

    localparam logic [Q_W-1:0] Q_MAX = 8'h7F;
    localparam logic [Q_W-1:0] Q_MIN = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One extra bit so that -32768 and -128 negate without wrapping.
    function automatic logic [DVD_W:0] mag_dvd(input logic [DVD_W-1:0] v);
        logic [DVD_W:0] e;
        e = {v[DVD_W-1], v};
        return v[DVD_W-1] ? -e : e;
    endfunction

    function automatic logic [DVS_W:0] mag_dvs(input logic [DVS_W-1:0] v);
        logic [DVS_W:0] e;
        e = {v[DVS_W-1], v};
        return v[DVS_W-1] ? -e : e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_div_step.sv
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring shift-subtract step.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
    import booth_div_pkg::*;
(
    input  logic [Q_W-1:0]   rem_in,
    input  logic [DVS_W:0]   dvs_mag,
    input  logic             dvd_bit,
    output logic [Q_W-1:0]   rem_out,
    output logic             q_bit
);

    logic [Q_W:0] w_trial;

    always_comb begin
        w_trial = {rem_in, dvd_bit};
        q_bit   = (w_trial >= dvs_mag);
        rem_out = q_bit ? Q_W'(w_trial - dvs_mag) : w_trial[Q_W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/booth_div.sv
// ============================================================================
// Module   : booth_div
// Purpose  : Signed 16/8 restoring divider, fixed 18-cycle latency.
//            BOOTH_DIV_EARLY_TERM_EN: zero divisor skips to DONE at cycle 2.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_div
    import booth_div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DVD_W-1:0]    dividend,
    input  logic [DVS_W-1:0]    divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [Q_W-1:0]      q,
    output logic [Q_W-1:0]      r,
    output logic                ovf,
    output logic                dz
);

    state_t             r_state, w_next;
    logic [4:0]         r_cnt;
    logic [DVD_W:0]     r_dvd;
    logic [DVS_W:0]     r_dvs;
    logic [Q_W-1:0]     r_rem;
    logic [Q_W-1:0]     r_lo;
    logic               r_neg_q, r_neg_r;

    logic [Q_W-1:0]     w_rem_nxt;
    logic               w_qbit;
    logic               w_dz, w_ovf;
    logic [Q_W-1:0]     w_q, w_r;

    div_step u_step (
        .rem_in  (r_rem),
        .dvs_mag (r_dvs),
        .dvd_bit (r_dvd[DVD_W-1]),
        .rem_out (w_rem_nxt),
        .q_bit   (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = RUN;
            RUN: begin
                if (r_cnt == 5'(ITER - 1)) w_next = FIX;
`ifdef BOOTH_DIV_EARLY_TERM_EN
                if (r_dvs == '0) w_next = DONE;
`endif
            end
            FIX:  w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_dvd holds the quotient magnitude once all iterations have shifted in.
    always_comb begin
        w_dz  = (r_dvs == '0);
        w_ovf = r_neg_q ? (r_dvd > 17'd128) : (r_dvd > 17'd127);
        w_r   = r_neg_r ? Q_W'(-r_rem) : r_rem;
        if (w_ovf) w_q = r_neg_q ? Q_MIN : Q_MAX;
        else       w_q = r_neg_q ? Q_W'(-r_dvd[Q_W-1:0]) : r_dvd[Q_W-1:0];
        if (w_dz) begin
            w_ovf = 1'b1;
            w_q   = r_neg_r ? Q_MIN : Q_MAX;
            w_r   = r_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            q       <= '0;
            r       <= '0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_dvd   <= mag_dvd(dividend);
                    r_dvs   <= mag_dvs(divisor);
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_lo    <= dividend[Q_W-1:0];
                    r_neg_q <= dividend[DVD_W-1] ^ divisor[DVS_W-1];
                    r_neg_r <= dividend[DVD_W-1];
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[DVD_W], r_dvd[DVD_W-2:0], w_qbit};
                    r_cnt <= r_cnt + 5'd1;
`ifdef BOOTH_DIV_EARLY_TERM_EN
                    if (w_dz) begin
                        q   <= w_q;
                        r   <= w_r;
                        ovf <= w_ovf;
                        dz  <= w_dz;
                    end
`endif
                end
                FIX: begin
                    q   <= w_q;
                    r   <= w_r;
                    ovf <= w_ovf;
                    dz  <= w_dz;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_booth_div.sv
// ============================================================================
// Module   : tb_booth_div
// Purpose  : Directed self-checking bench for booth_div.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_booth_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q, r;
    logic        ovf, dz;

    int tests = 0;
    int fails = 0;
    int dz_lat;

    booth_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        check("in_ready_before_accept", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the accept edge; cycle 1 has begun.
    task automatic wait_result(input string tag, input int lat, input logic [7:0] eq,
                               input logic [7:0] er, input logic eovf, input logic edz);
        int n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        $display("[TB] %s", tag);
        check("out_valid_seen", out_valid, 1);
        check("latency", n, lat);
        check("q", q, eq);
        check("r", r, er);
        check("ovf", ovf, eovf);
        check("dz", dz, edz);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_pop", in_ready, 1);
        check("out_valid_after_pop", out_valid, 0);
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [7:0] b, input int lat,
                       input logic [7:0] eq, input logic [7:0] er, input logic eovf, input logic edz);
        start_op(a, b);
        wait_result(tag, lat, eq, er, eovf, edz);
        pop();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef BOOTH_DIV_EARLY_TERM_EN
        dz_lat = 2;
`else
        dz_lat = 18;
`endif
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_ovf", ovf, 0);
        check("rst_dz", dz, 0);

        run("100/7",      16'd100,   8'd7,    18, 8'h0E, 8'h02, 0, 0);
        run("-100/7",     -16'sd100, 8'd7,    18, 8'hF2, 8'hFE, 0, 0);
        run("-1024/8",    -16'sd1024, 8'd8,   18, 8'h80, 8'h00, 0, 0);
        run("1000/3",     16'd1000,  8'd3,    18, 8'h7F, 8'h01, 1, 0);
        run("-32768/-1",  16'h8000,  8'hFF,   18, 8'h7F, 8'h00, 1, 0);
        run("1000/-128",  16'd1000,  8'h80,   18, 8'hF9, 8'h68, 0, 0);
        run("128/-1",     16'd128,   8'hFF,   18, 8'h80, 8'h00, 0, 0);
        run("128/1",      16'd128,   8'd1,    18, 8'h7F, 8'h00, 1, 0);
        run("-32768/-128",16'h8000,  8'h80,   18, 8'h7F, 8'h00, 1, 0);
        run("1234/0",     16'd1234,  8'd0,    dz_lat, 8'h7F, 8'hD2, 1, 1);
        run("-5/0",       -16'sd5,   8'd0,    dz_lat, 8'h80, 8'hFB, 1, 1);

        // Back-pressure: hold the result while a second operand is offered.
        start_op(16'd100, 8'd7);
        wait_result("backpressure", 18, 8'h0E, 8'h02, 0, 0);
        dividend = 16'd50; divisor = 8'd5; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_q", q, 8'h0E);
            check("bp_r", r, 8'h02);
        end
        in_valid = 1'b0;
        pop();
        check("bp_q_kept", q, 8'h0E);
        tick();
        check("bp_still_idle_out_valid", out_valid, 0);

        // Reset in the middle of RUN.
        start_op(16'd100, 8'd7);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_q", q, 0);
        repeat (20) begin
            tick();
            if (out_valid) break;
        end
        check("midrst_no_result", out_valid, 0);
        run("100/7 after reset", 16'd100, 8'd7, 18, 8'h0E, 8'h02, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
